hex_cmd_parser: RTL and testbench

Byte-stream command parser between the UART receiver and the configuration register file of the logic analyzer. It accepts ASCII command lines, uses the existing ascii_to_hex converter to turn each hex character into a nibble, and assembles address and data fields. It presents one complete write or read command at a time over a valid/ready handshake and reports malformed input with an error code.

---
 rtl/hex_cmd_parser_pkg.sv | 25 ++
 rtl/hex_cmd_parser_ascii_to_hex.sv | 21 ++
 rtl/hex_cmd_parser.sv | 179 +++++++++++++++++
 tb/tb_hex_cmd_parser.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hex_cmd_parser_pkg.sv
// Shared constants and state encoding for the hex command parser.
package hex_cmd_pkg;

  localparam logic [7:0] CH_W  = 8'h57;
  localparam logic [7:0] CH_R  = 8'h52;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;

  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_OPCODE   = 3'd1;
  localparam logic [2:0] ERR_HEX      = 3'd2;
  localparam logic [2:0] ERR_EARLY_CR = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT  = 3'd4;
  localparam logic [2:0] ERR_NO_CR    = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_EOL,
    ST_HOLD,
    ST_SYNC
  } state_e;

endpackage

// File: rtl/hex_cmd_parser_ascii_to_hex.sv
// ascii_to_hex: converts one uppercase ASCII hex character to a nibble.
// error is high for anything outside '0'-'9' and 'A'-'F'.
module ascii_to_hex (
  input  logic [7:0] ascii,
  output logic [3:0] hex_out,
  output logic       error
);

  always_comb begin
    hex_out = 4'd0;
    error   = 1'b0;
    if (ascii >= 8'h30 && ascii <= 8'h39) begin
      hex_out = ascii[3:0];
    end else if (ascii >= 8'h41 && ascii <= 8'h46) begin
      hex_out = ascii[3:0] + 4'd9;
    end else begin
      error = 1'b1;
    end
  end

endmodule

// File: rtl/hex_cmd_parser.sv
// hex_cmd_parser: turns ASCII "W<addr><data>\r" / "R<addr>\r" lines into commands.
// Optional idle-byte timeout is built when CMD_TIMEOUT_EN is defined.
//
// state | meaning
// IDLE  | waiting for 'W'/'R'; CR/LF ignored
// ADDR  | collecting address hex characters
// DATA  | collecting write-data hex characters
// EOL   | expecting the terminating CR
// HOLD  | command presented, waiting for cmd_ready
// SYNC  | discarding a bad line up to its CR
module hex_cmd_parser
  import hex_cmd_pkg::*;
#(
  parameter int ADDR_NIBBLES   = 2,
  parameter int DATA_NIBBLES   = 8,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rx_valid,
  input  logic [7:0]                rx_data,
  output logic                      rx_ready,
  output logic                      cmd_valid,
  input  logic                      cmd_ready,
  output logic                      cmd_write,
  output logic [4*ADDR_NIBBLES-1:0] cmd_addr,
  output logic [4*DATA_NIBBLES-1:0] cmd_wdata,
  output logic                      err_valid,
  output logic [2:0]                err_code
);

  localparam int AW    = 4 * ADDR_NIBBLES;
  localparam int DW    = 4 * DATA_NIBBLES;
  localparam int MAXN  = (ADDR_NIBBLES > DATA_NIBBLES) ? ADDR_NIBBLES : DATA_NIBBLES;
  localparam int CNT_W = $clog2(MAXN + 1);

  if (TIMEOUT_CYCLES < 2) begin : g_tmo_check
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  state_e           state_q, state_d;
  logic             write_q, write_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    wdata_q, wdata_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_v_d;
  logic [2:0]       err_c_d;
  logic [3:0]       nibble;
  logic             hex_err;
  logic             accept;

  ascii_to_hex u_ascii_to_hex (
    .ascii   (rx_data),
    .hex_out (nibble),
    .error   (hex_err)
  );

  assign rx_ready  = (state_q != ST_HOLD);
  assign accept    = rx_valid && rx_ready;
  assign cmd_valid = (state_q == ST_HOLD);
  assign cmd_write = write_q;
  assign cmd_addr  = addr_q;
  assign cmd_wdata = wdata_q;

`ifdef CMD_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
  logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

  always_comb begin
    state_d = state_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    err_v_d = 1'b0;
    err_c_d = ERR_NONE;
`ifdef CMD_TIMEOUT_EN
    tmo_d   = '0;
`endif
    case (state_q)
      ST_IDLE: if (accept) begin
        if (rx_data == CH_W || rx_data == CH_R) begin
          write_d = (rx_data == CH_W);
          addr_d  = '0;
          wdata_d = '0;
          cnt_d   = '0;
          state_d = ST_ADDR;
        end else if (rx_data != CH_CR && rx_data != CH_LF) begin
          err_v_d = 1'b1;
          err_c_d = ERR_OPCODE;
          state_d = ST_SYNC;
        end
      end
      ST_ADDR, ST_DATA: if (accept) begin
        if (rx_data == CH_CR) begin
          err_v_d = 1'b1;
          err_c_d = ERR_EARLY_CR;
          state_d = ST_IDLE;
        end else if (hex_err) begin
          err_v_d = 1'b1;
          err_c_d = ERR_HEX;
          state_d = ST_SYNC;
        end else if (state_q == ST_ADDR) begin
          addr_d = (addr_q << 4) | AW'(nibble);
          if (cnt_q == CNT_W'(ADDR_NIBBLES - 1)) begin
            cnt_d   = '0;
            state_d = write_q ? ST_DATA : ST_EOL;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          wdata_d = (wdata_q << 4) | DW'(nibble);
          if (cnt_q == CNT_W'(DATA_NIBBLES - 1)) begin
            cnt_d   = '0;
            state_d = ST_EOL;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_EOL: if (accept) begin
        if (rx_data == CH_CR) begin
          state_d = ST_HOLD;
        end else begin
          err_v_d = 1'b1;
          err_c_d = ERR_NO_CR;
          state_d = ST_SYNC;
        end
      end
      ST_HOLD: if (cmd_ready) state_d = ST_IDLE;
      ST_SYNC: if (accept && rx_data == CH_CR) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
`ifdef CMD_TIMEOUT_EN
    // Only idle cycles inside a line advance the timer; any accepted byte restarts it.
    if (!accept && (state_q == ST_ADDR || state_q == ST_DATA || state_q == ST_EOL)) begin
      if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
        err_v_d = 1'b1;
        err_c_d = ERR_TIMEOUT;
        state_d = ST_IDLE;
        addr_d  = '0;
        wdata_d = '0;
        cnt_d   = '0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      write_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      err_valid <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      state_q   <= state_d;
      write_q   <= write_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      err_valid <= err_v_d;
      err_code  <= err_c_d;
    end
  end

`ifdef CMD_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tmo_q <= '0;
    else        tmo_q <= tmo_d;
  end
`endif

endmodule

// File: tb/tb_hex_cmd_parser.sv
// Bench for hex_cmd_parser: directed scenarios plus random command streams
// checked against a line-grammar reference model.
module tb_hex_cmd_parser;

  typedef byte unsigned bq_t[$];

  logic        clk;
  logic        rst_n;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        err_valid;
  logic [2:0]  err_code;

  int checks   = 0;
  int failures = 0;

  logic [40:0] exp_cmd[$];
  logic [2:0]  exp_err[$];
  logic [40:0] obs_cmd[$];
  logic [2:0]  obs_err[$];
  bit          mon_en   = 0;
  bit          rnd_ready = 0;
  int          viol     = 0;

  hex_cmd_parser #(
    .ADDR_NIBBLES   (2),
    .DATA_NIBBLES   (8),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .err_valid (err_valid),
    .err_code  (err_code)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_ready) cmd_ready = 1'($urandom_range(0, 1));
    end
  end

  // Observer: collects errors/handshakes and protocol violations.
  initial begin
    bit          prev_err = 0, prev_cv = 0, prev_hs = 0;
    logic [40:0] prev_cmd = '0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (err_valid) obs_err.push_back(err_code);
        if (err_valid && prev_err) viol++;
        if (cmd_valid && rx_ready) viol++;
        if (prev_cv && !prev_hs && (!cmd_valid || {cmd_write, cmd_addr, cmd_wdata} != prev_cmd)) viol++;
        if (cmd_valid && cmd_ready) obs_cmd.push_back({cmd_write, cmd_addr, cmd_wdata});
      end
      prev_err = err_valid;
      prev_cv  = cmd_valid;
      prev_hs  = cmd_valid && cmd_ready;
      prev_cmd = {cmd_write, cmd_addr, cmd_wdata};
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  function automatic bq_t str2q(string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] == ".")      q.push_back(8'h0D);
      else if (s[i] == "|") q.push_back(8'h0A);
      else                  q.push_back(s[i]);
    end
    return q;
  endfunction

  function automatic bit is_hex(byte unsigned c);
    return (c >= "0" && c <= "9") || (c >= "A" && c <= "F");
  endfunction

  function automatic logic [3:0] hex_val(byte unsigned c);
    return (c <= "9") ? 4'(c - "0") : 4'(c - "A" + 10);
  endfunction

  function automatic byte unsigned hex_chr(int v);
    return (v < 10) ? 8'("0" + v) : 8'("A" + v - 10);
  endfunction

  // Reference: recursive-descent reading of the line grammar over a whole stream.
  task automatic model_stream(input bq_t s);
    int i = 0;
    exp_cmd.delete();
    exp_err.delete();
    while (i < s.size()) begin
      byte unsigned b = s[i++];
      bit wr, ok;
      int need;
      logic [39:0] val;
      if (b == 8'h0D || b == 8'h0A) continue;
      if (b != "W" && b != "R") begin
        exp_err.push_back(3'd1);
        while (i < s.size() && s[i++] != 8'h0D) ;
        continue;
      end
      wr   = (b == "W");
      need = wr ? 10 : 2;
      val  = '0;
      ok   = 1;
      for (int k = 0; k < need; k++) begin
        byte unsigned c;
        if (i >= s.size()) begin ok = 0; break; end
        c = s[i++];
        if (c == 8'h0D) begin exp_err.push_back(3'd3); ok = 0; break; end
        if (!is_hex(c)) begin
          exp_err.push_back(3'd2);
          while (i < s.size() && s[i++] != 8'h0D) ;
          ok = 0;
          break;
        end
        val = (val << 4) | 40'(hex_val(c));
      end
      if (ok && i < s.size()) begin
        byte unsigned c = s[i++];
        if (c == 8'h0D) begin
          if (wr) exp_cmd.push_back({1'b1, val[39:32], val[31:0]});
          else    exp_cmd.push_back({1'b0, val[7:0], 32'h0});
        end else begin
          exp_err.push_back(3'd5);
          while (i < s.size() && s[i++] != 8'h0D) ;
        end
      end
    end
  endtask

  // Called at posedge+1; returns at posedge+1 right after the byte was accepted.
  task automatic send_byte(input byte unsigned b);
    bit got = 0;
    rx_valid = 1;
    rx_data  = b;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (rx_ready) begin got = 1; break; end
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL send_byte: rx_ready stayed %0b for 200 cycles, required 1", rx_ready);
    end
    @(posedge clk);
    #1;
    rx_valid = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rx_valid = 0;
    rst_n    = 0;
    idle(2);
    rst_n = 1;
    idle(1);
  endtask

  task automatic run_stream(input string name, input bq_t s, input bit gaps);
    model_stream(s);
    obs_cmd.delete();
    obs_err.delete();
    mon_en = 1;
    foreach (s[k]) begin
      send_byte(s[k]);
      if (gaps) idle($urandom_range(0, 2));
    end
    rnd_ready = 0;
    cmd_ready = 1;
    idle(6);
    cmd_ready = 0;
    mon_en = 0;
    checks++;
    if (obs_cmd.size() != exp_cmd.size()) begin
      failures++;
      $display("FAIL %s cmd_count: got %0d, required %0d", name, obs_cmd.size(), exp_cmd.size());
    end
    for (int k = 0; k < exp_cmd.size() && k < obs_cmd.size(); k++) begin
      checks++;
      if (obs_cmd[k] !== exp_cmd[k]) begin
        failures++;
        $display("FAIL %s cmd[%0d]: got %h, required %h", name, k, obs_cmd[k], exp_cmd[k]);
      end
    end
    checks++;
    if (obs_err.size() != exp_err.size()) begin
      failures++;
      $display("FAIL %s err_count: got %0d, required %0d", name, obs_err.size(), exp_err.size());
    end
    for (int k = 0; k < exp_err.size() && k < obs_err.size(); k++) begin
      checks++;
      if (obs_err[k] !== exp_err[k]) begin
        failures++;
        $display("FAIL %s err[%0d]: got %0d, required %0d", name, k, obs_err[k], exp_err[k]);
      end
    end
  endtask

  task automatic test_reset();
    rx_valid  = 0;
    rx_data   = 0;
    cmd_ready = 0;
    rst_n     = 0;
    #12;
    checks++;
    if ({rx_ready, cmd_valid, cmd_write, cmd_addr, cmd_wdata, err_valid, err_code} !== {1'b1, 1'b0, 1'b0, 8'h0, 32'h0, 1'b0, 3'd0}) begin
      failures++;
      $display("FAIL reset_outputs: got rdy=%b cv=%b w=%b a=%h d=%h ev=%b ec=%0d, required 1 0 0 00 00000000 0 0",
               rx_ready, cmd_valid, cmd_write, cmd_addr, cmd_wdata, err_valid, err_code);
    end
    @(posedge clk);
    #1;
    rst_n = 1;
    idle(1);
  endtask

  task automatic test_write_basic();
    bq_t s = str2q("W1A0000BEEF.");
    int errs = 0;
    cmd_ready = 1;
    foreach (s[k]) send_byte(s[k]);
    @(negedge clk);
    if (err_valid) errs++;
    checks++;
    if ({cmd_valid, cmd_write, cmd_addr, cmd_wdata} !== {1'b1, 1'b1, 8'h1A, 32'h0000BEEF}) begin
      failures++;
      $display("FAIL write_basic: got cv=%b w=%b a=%h d=%h, required 1 1 1a 0000beef", cmd_valid, cmd_write, cmd_addr, cmd_wdata);
    end
    @(negedge clk);
    if (err_valid) errs++;
    checks++;
    if (cmd_valid !== 1'b0 || rx_ready !== 1'b1) begin
      failures++;
      $display("FAIL write_release: got cv=%b rdy=%b, required 0 1", cmd_valid, rx_ready);
    end
    checks++;
    if (errs != 0) begin
      failures++;
      $display("FAIL write_no_err: got %0d error pulses, required 0", errs);
    end
    cmd_ready = 0;
    idle(1);
  endtask

  task automatic test_hold();
    bq_t s = str2q("R3F.");
    int hi = 0, rdy_hi = 0;
    logic [40:0] f;
    cmd_ready = 0;
    foreach (s[k]) send_byte(s[k]);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (cmd_valid) hi++;
      if (rx_ready) rdy_hi++;
    end
    @(posedge clk);
    #1;
    cmd_ready = 1;
    @(negedge clk);
    if (cmd_valid) hi++;
    if (rx_ready) rdy_hi++;
    f = {cmd_write, cmd_addr, cmd_wdata};
    @(posedge clk);
    #1;
    cmd_ready = 0;
    @(negedge clk);
    checks++;
    if (hi != 6 || cmd_valid !== 1'b0) begin
      failures++;
      $display("FAIL hold_len: got %0d valid cycles (after=%b), required 6 (after=0)", hi, cmd_valid);
    end
    checks++;
    if (rdy_hi != 0) begin
      failures++;
      $display("FAIL hold_rx_ready: got %0d ready cycles in hold, required 0", rdy_hi);
    end
    checks++;
    if (f !== {1'b0, 8'h3F, 32'h0}) begin
      failures++;
      $display("FAIL hold_fields: got %h, required %h", f, {1'b0, 8'h3F, 32'h0});
    end
  endtask

  task automatic test_errors();
    run_stream("bad_hex", str2q("W1G12345.R01."), 0);
    checks++;
    if (obs_err.size() != 1 || obs_err[0] !== 3'd2 || obs_cmd.size() != 1 || obs_cmd[0][39:32] !== 8'h01) begin
      failures++;
      $display("FAIL bad_hex_direct: got %0d errs, %0d cmds, required one code 2 and addr 01", obs_err.size(), obs_cmd.size());
    end
    run_stream("opcode_early_cr", str2q("X.R5."), 0);
    checks++;
    if (obs_err.size() != 2 || obs_err[0] !== 3'd1 || obs_err[1] !== 3'd3 || obs_cmd.size() != 0) begin
      failures++;
      $display("FAIL opcode_early_cr_direct: got %0d errs, %0d cmds, required codes 1,3 and none", obs_err.size(), obs_cmd.size());
    end
    run_stream("no_cr", str2q("|R22Z.W0012345678."), 1);
    checks++;
    if (obs_err.size() != 1 || obs_err[0] !== 3'd5) begin
      failures++;
      $display("FAIL no_cr_direct: got %0d errs, required one code 5", obs_err.size());
    end
  endtask

  task automatic test_reset_midline();
    bq_t s = str2q("R22.");
    int ev = 0;
    cmd_ready = 0;
    foreach (s[k]) send_byte(s[k]);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 0;
    #1;
    checks++;
    if (cmd_valid !== 1'b0 || rx_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_hold: got cv=%b rdy=%b, required 0 1", cmd_valid, rx_ready);
    end
    @(posedge clk);
    #1;
    rst_n = 1;
    s = str2q("W12");
    foreach (s[k]) send_byte(s[k]);
    rst_n = 0;
    #2;
    rst_n = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (err_valid || cmd_valid) ev++;
    end
    checks++;
    if (ev != 0) begin
      failures++;
      $display("FAIL reset_no_event: got %0d event cycles, required 0", ev);
    end
    @(posedge clk);
    #1;
    run_stream("after_reset", str2q("R34."), 0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      bq_t s;
      for (int n = 0; n < 40; n++) begin
        bq_t l;
        bit wr = 1'($urandom_range(0, 1));
        int mut;
        l.push_back(wr ? "W" : "R");
        for (int k = 0; k < (wr ? 10 : 2); k++) l.push_back(hex_chr($urandom_range(0, 15)));
        l.push_back(8'h0D);
        mut = $urandom_range(0, 5);
        if (mut == 0) l[$urandom_range(0, l.size() - 2)] = 8'($urandom_range(0, 255));
        else if (mut == 1) l.insert($urandom_range(1, l.size() - 1), 8'($urandom_range(0, 255)));
        else if (mut == 2) l.push_front(8'h0A);
        foreach (l[k]) s.push_back(l[k]);
      end
      s.push_back(8'h0D);
      rnd_ready = 1;
      run_stream($sformatf("random%0d", r), s, 1);
    end
    checks++;
    if (viol != 0) begin
      failures++;
      $display("FAIL protocol: got %0d hold/pulse violations, required 0", viol);
    end
  endtask

`ifdef CMD_TIMEOUT_EN
  task automatic test_timeout();
    bq_t s = str2q("W12");
    int early = 0;
    foreach (s[k]) send_byte(s[k]);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (err_valid) early++;
    end
    @(negedge clk);
    checks++;
    if (early != 0 || err_valid !== 1'b1 || err_code !== 3'd4 || rx_ready !== 1'b1) begin
      failures++;
      $display("FAIL timeout: got early=%0d ev=%b ec=%0d, required 0 1 4", early, err_valid, err_code);
    end
    @(posedge clk);
    #1;
    run_stream("after_timeout", str2q("R12."), 0);
  endtask
`endif

  initial begin
    rx_valid  = 0;
    rx_data   = 0;
    cmd_ready = 0;
    rst_n     = 0;
    test_reset();
    test_write_basic();
    test_hold();
    test_errors();
    test_reset_midline();
`ifdef CMD_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
